// File: rtl/can_bitdestuff.sv
// Receive-side CAN bit de-stuffer: forwards data bits, drops stuff bits, flags six-in-a-row.
// Optional CAN_DESTUFF_ERRCNT_EN adds a saturating stuff-error counter output (stuff_err_cnt).
module can_bitdestuff #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned RUN_W     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_point,
  input  logic       bit_in,
  input  logic       stuff_en,
  input  logic       clear,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       stuff_removed,
`ifdef CAN_DESTUFF_ERRCNT_EN
  output logic       stuff_err,
  output logic [7:0] stuff_err_cnt
`else
  output logic       stuff_err
`endif
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACTIVE       = 2'd1,
    EXPECT_STUFF = 2'd2,
    ERROR        = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             r_prev_bit;
  logic             w_prev_nxt;
  logic             r_bit_out;
  logic             w_bit_out_nxt;
  logic             r_bit_valid;
  logic             w_bit_valid_nxt;
  logic             r_stuff_removed;
  logic             w_stuff_removed_nxt;
  logic             r_stuff_err;
  logic             w_stuff_err_nxt;

  // State, run tracking and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_run_cnt       <= '0;
      r_prev_bit      <= 1'b1;
      r_bit_out       <= 1'b1;
      r_bit_valid     <= 1'b0;
      r_stuff_removed <= 1'b0;
      r_stuff_err     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_run_cnt       <= w_run_nxt;
      r_prev_bit      <= w_prev_nxt;
      r_bit_out       <= w_bit_out_nxt;
      r_bit_valid     <= w_bit_valid_nxt;
      r_stuff_removed <= w_stuff_removed_nxt;
      r_stuff_err     <= w_stuff_err_nxt;
    end
  end

  // Next-state and output decode; clear overrides any sample in the same cycle
  always_comb begin
    w_state_nxt         = r_state;
    w_run_nxt           = r_run_cnt;
    w_prev_nxt          = r_prev_bit;
    w_bit_out_nxt       = r_bit_out;
    w_bit_valid_nxt     = 1'b0;
    w_stuff_removed_nxt = 1'b0;
    w_stuff_err_nxt     = r_stuff_err;

    if (clear) begin
      w_state_nxt     = IDLE;
      w_run_nxt       = '0;
      w_prev_nxt      = 1'b1;
      w_stuff_err_nxt = 1'b0;
    end else if (sample_point) begin
      unique case (r_state)
        IDLE: begin
          w_bit_valid_nxt = 1'b1;
          w_bit_out_nxt   = bit_in;
          if (stuff_en) begin
            w_run_nxt   = RUN_ONE;
            w_prev_nxt  = bit_in;
            w_state_nxt = ACTIVE;
          end
        end

        ACTIVE: begin
          w_bit_valid_nxt = 1'b1;
          w_bit_out_nxt   = bit_in;
          if (!stuff_en) begin
            w_run_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_run_nxt  = (bit_in == r_prev_bit) ? (r_run_cnt + RUN_ONE) : RUN_ONE;
            w_prev_nxt = bit_in;
            if (w_run_nxt == RUN_MAX) begin
              w_state_nxt = EXPECT_STUFF;
            end
          end
        end

        // Consumed regardless of stuff_en so a stuff bit after the last CRC bit is dropped
        EXPECT_STUFF: begin
          if (bit_in != r_prev_bit) begin
            w_stuff_removed_nxt = 1'b1;
            w_run_nxt           = RUN_ONE;
            w_prev_nxt          = bit_in;
            w_state_nxt         = stuff_en ? ACTIVE : IDLE;
          end else begin
            w_stuff_err_nxt = 1'b1;
            w_state_nxt     = ERROR;
          end
        end

        ERROR: begin
          w_state_nxt = ERROR;
        end

        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bit_out       = r_bit_out;
  assign bit_valid     = r_bit_valid;
  assign stuff_removed = r_stuff_removed;
  assign stuff_err     = r_stuff_err;

`ifdef CAN_DESTUFF_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Counts entries into ERROR; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if ((r_state != ERROR) && (w_state_nxt == ERROR) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign stuff_err_cnt = r_err_cnt;
`endif

endmodule
